// File: rtl/calc_cmd_ctrl.sv
// calc_cmd_ctrl: parses "A op B =" ASCII frames from the UART byte strobe
// and issues one ALU command per frame over a valid/ready handshake.
//
// Ports:
//   clk, rst          clock, async active-high reset
//   rx_en, rx_data    one-cycle byte strobe and received byte
//   op_a, op_b        issued operands (OPW bits, unsigned)
//   opcode            00 add, 01 sub, 10 mul, 11 div
//   cmd_valid         command held for the ALU
//   cmd_ready         ALU accepts the command
//   err, err_code     one-cycle error pulse; code held until next error
//                     (00 overrun, 01 overflow, 10 syntax, 11 timeout)
//   busy              high whenever the sequencer is not idle
//
// Optional build macro CALC_RX_TIMEOUT_EN adds the inter-byte timeout
// (error code 11) while an operand is being assembled.

module calc_cmd_ctrl #(
  parameter int OPW            = 16,
  parameter int MAX_DIGITS     = 5,
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int TW             = 26
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rx_en,
  input  logic [7:0]     rx_data,
  output logic [OPW-1:0] op_a,
  output logic [OPW-1:0] op_b,
  output logic [1:0]     opcode,
  output logic           cmd_valid,
  input  logic           cmd_ready,
  output logic           err,
  output logic [1:0]     err_code,
  output logic           busy
);

  localparam int CW = $clog2(MAX_DIGITS + 1);

  localparam logic [1:0] E_OVR = 2'b00;
  localparam logic [1:0] E_OVF = 2'b01;
  localparam logic [1:0] E_SYN = 2'b10;
  localparam logic [1:0] E_TMO = 2'b11;

  if (TIMEOUT_CYCLES >= 2 ** TW) begin : g_tw_check
    $error("TW too narrow for TIMEOUT_CYCLES");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OPA   = 2'd1,
    OPB   = 2'd2,
    ISSUE = 2'd3
  } state_t;

  state_t          state, state_n;
  logic [OPW-1:0]  acc_a, acc_a_n;
  logic [OPW-1:0]  acc_b, acc_b_n;
  logic [CW-1:0]   cnt_a, cnt_a_n;
  logic [CW-1:0]   cnt_b, cnt_b_n;
  logic [1:0]      opc, opc_n;
  logic [OPW-1:0]  op_a_n, op_b_n;
  logic [1:0]      opcode_n;
  logic            err_n;
  logic [1:0]      err_code_n;

  logic            fault;
  logic [1:0]      fcode;
  logic [OPW+3:0]  nxt_a, nxt_b;
  logic            ovf_a, ovf_b;

  logic            is_dig, is_op, is_eq, is_sp, is_clr;
  logic [1:0]      opv;

`ifdef CALC_RX_TIMEOUT_EN
  logic [TW-1:0]   tmo, tmo_n;
`endif

  // acc*10 + d as shifts; the 4 extra bits make overflow visible
  function automatic logic [OPW+3:0] mac(
    input logic [OPW-1:0] a,
    input logic [3:0]     d
  );
    logic [OPW+3:0] w;
    w = {4'b0, a};
    return (w << 3) + (w << 1) + {{OPW{1'b0}}, d};
  endfunction

  assign is_dig = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign is_op  = (rx_data == 8'h2B) || (rx_data == 8'h2D) ||
                  (rx_data == 8'h2A) || (rx_data == 8'h2F);
  assign is_eq  = (rx_data == 8'h3D);
  assign is_sp  = (rx_data == 8'h20);
  assign is_clr = (rx_data == 8'h43) || (rx_data == 8'h63);
  assign opv    = {(rx_data == 8'h2A) || (rx_data == 8'h2F),
                   (rx_data == 8'h2D) || (rx_data == 8'h2F)};

  assign nxt_a = mac(acc_a, rx_data[3:0]);
  assign nxt_b = mac(acc_b, rx_data[3:0]);
  assign ovf_a = (|nxt_a[OPW+3:OPW]) || (cnt_a >= CW'(MAX_DIGITS));
  assign ovf_b = (|nxt_b[OPW+3:OPW]) || (cnt_b >= CW'(MAX_DIGITS));

  assign busy      = (state != IDLE);
  assign cmd_valid = (state == ISSUE);

  always_comb begin
    state_n    = state;
    acc_a_n    = acc_a;
    acc_b_n    = acc_b;
    cnt_a_n    = cnt_a;
    cnt_b_n    = cnt_b;
    opc_n      = opc;
    op_a_n     = op_a;
    op_b_n     = op_b;
    opcode_n   = opcode;
    err_n      = 1'b0;
    err_code_n = err_code;
    fault      = 1'b0;
    fcode      = E_SYN;
`ifdef CALC_RX_TIMEOUT_EN
    tmo_n      = '0;
`endif

    if (rx_en) begin
      if (state == ISSUE) begin
        // command stays held; the byte is lost
        err_n      = 1'b1;
        err_code_n = E_OVR;
      end else begin
        unique case (1'b1)
          is_sp: ;
          is_clr: begin
            state_n = IDLE;
            acc_a_n = '0;
            acc_b_n = '0;
            cnt_a_n = '0;
            cnt_b_n = '0;
          end
          is_dig: begin
            unique case (state)
              IDLE: begin
                acc_a_n = {{(OPW-4){1'b0}}, rx_data[3:0]};
                cnt_a_n = CW'(1);
                state_n = OPA;
              end
              OPA: begin
                if (ovf_a) begin
                  fault = 1'b1;
                  fcode = E_OVF;
                end else begin
                  acc_a_n = nxt_a[OPW-1:0];
                  cnt_a_n = cnt_a + 1'b1;
                end
              end
              OPB: begin
                if (ovf_b) begin
                  fault = 1'b1;
                  fcode = E_OVF;
                end else begin
                  acc_b_n = nxt_b[OPW-1:0];
                  cnt_b_n = cnt_b + 1'b1;
                end
              end
              default: ;
            endcase
          end
          is_op: begin
            if (state == OPA) begin
              opc_n   = opv;
              acc_b_n = '0;
              cnt_b_n = '0;
              state_n = OPB;
            end else begin
              fault = 1'b1;
            end
          end
          is_eq: begin
            if (state == OPB && cnt_b != '0) begin
              op_a_n   = acc_a;
              op_b_n   = acc_b;
              opcode_n = opc;
              state_n  = ISSUE;
            end else begin
              fault = 1'b1;
            end
          end
          default: fault = 1'b1;
        endcase
      end
    end

    if (state == ISSUE && cmd_ready)
      state_n = IDLE;

`ifdef CALC_RX_TIMEOUT_EN
    // any strobe restarts the window, including the one entering OPA/OPB
    if ((state == OPA || state == OPB) && !rx_en) begin
      if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
        fault = 1'b1;
        fcode = E_TMO;
      end else begin
        tmo_n = tmo + 1'b1;
      end
    end
`endif

    if (fault) begin
      err_n      = 1'b1;
      err_code_n = fcode;
      state_n    = IDLE;
      acc_a_n    = '0;
      acc_b_n    = '0;
      cnt_a_n    = '0;
      cnt_b_n    = '0;
`ifdef CALC_RX_TIMEOUT_EN
      tmo_n      = '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      acc_a    <= '0;
      acc_b    <= '0;
      cnt_a    <= '0;
      cnt_b    <= '0;
      opc      <= '0;
      op_a     <= '0;
      op_b     <= '0;
      opcode   <= '0;
      err      <= 1'b0;
      err_code <= '0;
`ifdef CALC_RX_TIMEOUT_EN
      tmo      <= '0;
`endif
    end else begin
      state    <= state_n;
      acc_a    <= acc_a_n;
      acc_b    <= acc_b_n;
      cnt_a    <= cnt_a_n;
      cnt_b    <= cnt_b_n;
      opc      <= opc_n;
      op_a     <= op_a_n;
      op_b     <= op_b_n;
      opcode   <= opcode_n;
      err      <= err_n;
      err_code <= err_code_n;
`ifdef CALC_RX_TIMEOUT_EN
      tmo      <= tmo_n;
`endif
    end
  end

endmodule

// File: tb/tb_calc_cmd_ctrl.sv
// Scoreboard bench for calc_cmd_ctrl: stimulus pushes expected commands
// and error codes; a negedge monitor pops and compares them.

module tb_calc_cmd_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_en = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [15:0] op_a, op_b;
  logic [1:0]  opcode;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic        err;
  logic [1:0]  err_code;
  logic        busy;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
  } cmd_t;

  cmd_t       exp_cmd[$];
  logic [1:0] exp_err[$];

  int checks = 0;
  int failures = 0;

  calc_cmd_ctrl #(
    .OPW(16),
    .MAX_DIGITS(5),
    .TIMEOUT_CYCLES(100),
    .TW(26)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_en(rx_en),
    .rx_data(rx_data),
    .op_a(op_a),
    .op_b(op_b),
    .opcode(opcode),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .err(err),
    .err_code(err_code),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    cmd_t       c;
    logic [1:0] e;
    if (!rst) begin
      if (err) begin
        if (exp_err.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL err_unexpected got code=%0d want none",
                   err_code);
        end else begin
          e = exp_err.pop_front();
          chk("sb_err_code", int'(err_code), int'(e));
        end
      end
      if (cmd_valid && cmd_ready) begin
        if (exp_cmd.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL cmd_unexpected got a=%0d b=%0d op=%0d",
                   op_a, op_b, opcode);
        end else begin
          c = exp_cmd.pop_front();
          chk("sb_cmd", int'({op_a, op_b, opcode}), int'(c));
        end
      end
    end
  end

  // called at posedge+1; returns at posedge+1 after the strobe cycle
  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_en   = 1'b1;
    @(posedge clk);
    #1;
    rx_en   = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2;
    chk("rst_cmd_valid", int'(cmd_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_err_code", int'(err_code), 0);
    chk("rst_ops", int'({op_a, op_b, opcode}), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // 12+34= with ready high
    cmd_ready = 1'b1;
    exp_cmd.push_back('{16'd12, 16'd34, 2'b00});
    send_str("12+34");
    chk("t1_busy_mid", int'(busy), 1);
    send("=");
    chk("t1_valid_latency", int'(cmd_valid), 1);
    idle(1);
    chk("t1_busy_after", int'(busy), 0);
    chk("t1_valid_after", int'(cmd_valid), 0);

    // 65535 * 2 = with a 10-cycle stall
    cmd_ready = 1'b0;
    exp_cmd.push_back('{16'd65535, 16'd2, 2'b10});
    send_str("65535 * 2 =");
    for (int i = 0; i < 10; i++) begin
      chk("t2_hold_valid", int'(cmd_valid), 1);
      chk("t2_hold_ops", int'({op_a, op_b, opcode}),
          int'({16'd65535, 16'd2, 2'b10}));
      idle(1);
    end
    cmd_ready = 1'b1;
    idle(1);
    cmd_ready = 1'b0;
    chk("t2_busy_after", int'(busy), 0);

    // 65536 overflows on the last digit
    send_str("6553");
    exp_err.push_back(2'b01);
    send("6");
    chk("t3_err", int'(err), 1);
    chk("t3_err_code", int'(err_code), 1);
    chk("t3_busy", int'(busy), 0);
    cmd_ready = 1'b1;
    exp_cmd.push_back('{16'd7, 16'd7, 2'b11});
    send_str("7/7=");
    chk("t3_valid", int'(cmd_valid), 1);
    idle(1);
    cmd_ready = 1'b0;

    // six digits overflow by count
    send_str("00000");
    exp_err.push_back(2'b01);
    send("1");
    chk("t4_err", int'(err), 1);

    // syntax errors
    exp_err.push_back(2'b10);
    send("+");
    chk("t5_plus_err", int'(err), 1);
    chk("t5_plus_code", int'(err_code), 2);
    send("5");
    exp_err.push_back(2'b10);
    send("=");
    chk("t5_eq_in_opa", int'(err), 1);
    send_str("3-");
    exp_err.push_back(2'b10);
    send("=");
    chk("t5_empty_b", int'(err), 1);
    chk("t5_busy", int'(busy), 0);
    send_str("3-");
    exp_err.push_back(2'b10);
    send("x");
    chk("t5_x_err", int'(err), 1);
    idle(3);
    chk("t5_code_held", int'(err_code), 2);
    chk("t5_err_pulse", int'(err), 0);

    // silent clear
    send_str("9+C");
    chk("t6_clr_err", int'(err), 0);
    chk("t6_clr_busy", int'(busy), 0);
    send_str("12c");
    chk("t6_clr_busy2", int'(busy), 0);

    // overrun while a command is pending, then reset
    send_str("1+1=");
    exp_err.push_back(2'b00);
    send("5");
    chk("t7_err", int'(err), 1);
    chk("t7_err_code", int'(err_code), 0);
    chk("t7_valid", int'(cmd_valid), 1);
    chk("t7_ops", int'({op_a, op_b}), int'({16'd1, 16'd1}));
    send("C");
    chk("t7_c_overrun", int'(err), 1);
    chk("t7_c_valid", int'(cmd_valid), 1);
    exp_err.push_back(2'b00);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("t7_rst_valid", int'(cmd_valid), 0);
    chk("t7_rst_busy", int'(busy), 0);
    chk("t7_rst_op_a", int'(op_a), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);

`ifdef CALC_RX_TIMEOUT_EN
    exp_err.push_back(2'b11);
    send("4");
    idle(99);
    chk("t8_no_tmo_yet", int'(err), 0);
    idle(1);
    chk("t8_tmo_err", int'(err), 1);
    chk("t8_tmo_code", int'(err_code), 3);
    chk("t8_tmo_busy", int'(busy), 0);
    send("4");
    idle(99);
    send("+");
    chk("t8_plus_ok", int'(err), 0);
    chk("t8_plus_busy", int'(busy), 1);
    send("C");
`else
    send("4");
    idle(200);
    chk("t8_wait_busy", int'(busy), 1);
    chk("t8_wait_err", int'(err), 0);
    send("C");
`endif

    idle(3);
    chk("sb_cmd_drained", exp_cmd.size(), 0);
    chk("sb_err_drained", exp_err.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/calc_cmd_ctrl.md
Name: calc_cmd_ctrl

Overview:
- Command sequencer between the UART byte receiver and the calculator ALU.
- Consumes the receiver's one-cycle byte strobe and parses ASCII frames of the form "A op B =".
- Assembles unsigned decimal operands and an opcode, then issues one command to the ALU over a valid/ready handshake.
- Reports syntax, overflow, overrun and timeout errors; recovers to idle without a reset.

Parameters:
OPW, 16, operand width in bits (unsigned).
MAX_DIGITS, 5, maximum decimal digits per operand.
TIMEOUT_CYCLES, 50000000, inter-byte timeout in clk cycles (1 s at 50 MHz).
TW, 26, timeout counter width; must satisfy 2^TW > TIMEOUT_CYCLES.

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  asynchronous, active-high reset
rx_en  in  1  one-cycle strobe, rx_data valid
rx_data  in  8  received byte
op_a  out  OPW  operand A
op_b  out  OPW  operand B
opcode  out  2  00 add, 01 sub, 10 mul, 11 div
cmd_valid  out  1  command available
cmd_ready  in  1  ALU accepts command
err  out  1  one-cycle error pulse
err_code  out  2  00 overrun, 01 overflow, 10 syntax, 11 timeout; held until the next err
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, active-high): state=IDLE; op_a, op_b, opcode, cmd_valid, err, err_code, busy=0; accumulators, digit counts and timeout counter=0.
- Character classes:
  - digit: 0x30-0x39.
  - operators: '+'0x2B->00, '-'0x2D->01, '*'0x2A->10, '/'0x2F->11.
  - '=' 0x3D.
  - space 0x20: ignored in every state.
  - 'C'/'c' (0x43/0x63): silent clear to IDLE with no err, except in ISSUE (see ISSUE).
  - any other byte: syntax error.
- States:
  - IDLE: digit -> load acc_a=digit, cnt=1, go OPA. Operator or '=' -> syntax error.
  - OPA: digit -> accumulate into acc_a. Operator -> latch opcode, clear acc_b and count, go OPB. '=' -> syntax error.
  - OPB: digit -> accumulate into acc_b. '=' with at least one B digit -> copy acc_a/acc_b/opcode to op_a/op_b/opcode, go ISSUE. '=' with zero B digits, or an operator -> syntax error.
  - ISSUE: cmd_valid=1; op_a, op_b and opcode held stable. Cycle with cmd_valid&&cmd_ready -> cmd_valid=0 next cycle, go IDLE. Any rx_en in ISSUE (including 'C') -> byte dropped, err pulse with code 00, command still held.
- Accumulate: next = acc*10 + (rx_data-0x30), computed in OPW+4 bits as (acc<<3)+(acc<<1)+d.
  - Overflow error (code 01) if next > 2^OPW-1 or the digit count would exceed MAX_DIGITS.
- Error action: err=1 for exactly one cycle, err_code updated the same cycle, state=IDLE, accumulators cleared. op_a/op_b keep their last issued values.
- Latency:
  - '=' strobe in cycle N -> cmd_valid=1 in N+1.
  - Offending byte strobe in cycle N -> err=1 in N+1.
  - Each byte is processed in its strobe cycle; back-to-back strobes are handled.
- cmd_ready held high while IDLE has no effect. cmd_valid never drops without a handshake, except on rst.
- rx_en=0: no state change (apart from the timeout counter).

Optional Feature:
- Macro CALC_RX_TIMEOUT_EN.
- When defined:
  - A TW-bit counter clears on every rx_en and on every entry to OPA/OPB, and increments while in OPA or OPB.
  - On reaching TIMEOUT_CYCLES-1 with no strobe: timeout error (code 11), go IDLE.
  - Counter is inactive in IDLE and ISSUE.
- When undefined: no counter logic; partial frames wait indefinitely and code 11 is never produced.

Test Plan:
- "12+34=" sent with cmd_ready=1 -> cmd_valid one cycle after '=', op_a=12, op_b=34, opcode=00; busy=0 after the handshake; err never asserted.
- "65535 * 2 =" with cmd_ready=0 for 10 cycles, then 1 -> op_a=65535, op_b=2, opcode=10; cmd_valid held high for all 10 cycles with operands stable.
- "65536" -> err pulse with code 01 on the '6' strobe; state IDLE. Then "7/7=" -> op_a=7, op_b=7, opcode=11.
- "+5=" -> err code 10 on '+'. "3-=" -> err code 10 on '='. "3-x" -> err code 10 on 'x'. "9+C" -> no err, busy=0.
- "1+1=" with cmd_ready=0, then "5" sent -> err code 00; cmd_valid stays 1 with op_a=1, op_b=1; assert rst mid-ISSUE -> cmd_valid=0 and busy=0 immediately.
- CALC_RX_TIMEOUT_EN with TIMEOUT_CYCLES=100: send "4", then idle 100 cycles -> err code 11, state IDLE. Idle 99 cycles, then "+" -> no error.
